// File: rtl/ipif_arb2.sv
// rtl/ipif_arb2.sv - two-requester IPIF register-bank arbiter with independent write/read paths
// Each path: round-robin grant, single outstanding access, timeout-forced completion.

module ipif_arb2_ctl #(
    parameter int C_TIMEOUT = 4
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic [1:0] i_req,
    input  logic       i_ack,
    output logic [1:0] o_take,
    output logic       o_issue,
    output logic       o_win,
    output logic       o_m_req,
    output logic [1:0] o_s_ack,
    output logic       o_timeout
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    state_t     r_state;
    logic [1:0] r_pend;
    logic [1:0] r_s_ack;
    logic       r_gnt;
    logic       r_last;
    logic       r_m_req;
    logic       r_timeout;
    logic [3:0] r_cnt;

    logic [1:0] w_busy;
    logic [1:0] w_cand;
    logic       w_active;
    logic       w_expire;

    always_comb begin
        w_active = (r_state != IDLE);
        w_busy   = r_pend;
        if (w_active) w_busy[r_gnt] = 1'b1;
        // a request from a requester already pending or in flight is dropped
        o_take   = i_req & ~w_busy;
        w_cand   = r_pend | o_take;
        o_win    = (w_cand == 2'b11) ? ~r_last : w_cand[1];
        o_issue  = !w_active && (w_cand != 2'b00);
        w_expire = w_active && !i_ack && (r_cnt == 4'(C_TIMEOUT - 1));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= IDLE;
            r_pend    <= 2'b00;
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            r_cnt     <= 4'd0;
            r_m_req   <= 1'b0;
            r_s_ack   <= 2'b00;
            r_timeout <= 1'b0;
        end else begin
            r_m_req   <= 1'b0;
            r_s_ack   <= 2'b00;
            r_timeout <= 1'b0;
            r_pend    <= w_cand;
            if (o_issue) r_pend[o_win] <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (o_issue) begin
                        r_state <= ISSUE;
                        r_gnt   <= o_win;
                        r_last  <= o_win;
                        r_m_req <= 1'b1;
                        r_cnt   <= 4'd0;
                    end
                end
                default: begin
                    if (i_ack || w_expire) begin
                        r_state          <= IDLE;
                        r_s_ack[r_gnt]   <= 1'b1;
                        r_timeout        <= !i_ack;
                    end else begin
                        r_state <= WAIT;
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    assign o_m_req   = r_m_req;
    assign o_s_ack   = r_s_ack;
    assign o_timeout = r_timeout;
endmodule

module ipif_arb2 #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_TIMEOUT    = 4
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [C_ADDR_WIDTH-3:0]   s0_wr_addr,
    input  logic                      s0_wr_req,
    input  logic [C_DATA_WIDTH/8-1:0] s0_wr_be,
    input  logic [C_DATA_WIDTH-1:0]   s0_wr_data,
    output logic                      s0_wr_ack,
    input  logic [C_ADDR_WIDTH-3:0]   s0_rd_addr,
    input  logic                      s0_rd_req,
    output logic [C_DATA_WIDTH-1:0]   s0_rd_data,
    output logic                      s0_rd_ack,
    input  logic [C_ADDR_WIDTH-3:0]   s1_wr_addr,
    input  logic                      s1_wr_req,
    input  logic [C_DATA_WIDTH/8-1:0] s1_wr_be,
    input  logic [C_DATA_WIDTH-1:0]   s1_wr_data,
    output logic                      s1_wr_ack,
    input  logic [C_ADDR_WIDTH-3:0]   s1_rd_addr,
    input  logic                      s1_rd_req,
    output logic [C_DATA_WIDTH-1:0]   s1_rd_data,
    output logic                      s1_rd_ack,
    output logic [C_ADDR_WIDTH-3:0]   m_wr_addr,
    output logic [C_DATA_WIDTH/8-1:0] m_wr_be,
    output logic [C_DATA_WIDTH-1:0]   m_wr_data,
    output logic                      m_wr_req,
    input  logic                      m_wr_ack,
    output logic [C_ADDR_WIDTH-3:0]   m_rd_addr,
    output logic                      m_rd_req,
    input  logic [C_DATA_WIDTH-1:0]   m_rd_data,
    input  logic                      m_rd_ack,
    output logic                      wr_timeout,
    output logic                      rd_timeout
);
    localparam int AW = C_ADDR_WIDTH - 2;
    localparam int DW = C_DATA_WIDTH;
    localparam int BW = C_DATA_WIDTH / 8;

    if (!(C_DATA_WIDTH == 32 || C_DATA_WIDTH == 64)) begin : g_bad_data_width
        $error("ipif_arb2: C_DATA_WIDTH must be 32 or 64");
    end
    if (C_TIMEOUT < 1 || C_TIMEOUT > 15) begin : g_bad_timeout
        $error("ipif_arb2: C_TIMEOUT must be 1..15");
    end

    logic [1:0][AW-1:0] w_wa, w_ra, r_wa, r_ra;
    logic [1:0][BW-1:0] w_wbe, r_wbe;
    logic [1:0][DW-1:0] w_wd, r_wd, r_rd_hold, w_rd_data;
    logic [DW-1:0]      r_rd_cap;
    logic [AW-1:0]      r_m_wr_addr, r_m_rd_addr;
    logic [BW-1:0]      r_m_wr_be;
    logic [DW-1:0]      r_m_wr_data;

    logic [1:0] w_wr_take, w_wr_sack, w_rd_take, w_rd_sack;
    logic       w_wr_issue, w_wr_win, w_rd_issue, w_rd_win;

    assign w_wa  = {s1_wr_addr, s0_wr_addr};
    assign w_wbe = {s1_wr_be, s0_wr_be};
    assign w_wd  = {s1_wr_data, s0_wr_data};
    assign w_ra  = {s1_rd_addr, s0_rd_addr};

    ipif_arb2_ctl #(.C_TIMEOUT(C_TIMEOUT)) u_wr_ctl (
        .aclk(aclk), .areset(areset), .i_req({s1_wr_req, s0_wr_req}), .i_ack(m_wr_ack),
        .o_take(w_wr_take), .o_issue(w_wr_issue), .o_win(w_wr_win),
        .o_m_req(m_wr_req), .o_s_ack(w_wr_sack), .o_timeout(wr_timeout)
    );

    ipif_arb2_ctl #(.C_TIMEOUT(C_TIMEOUT)) u_rd_ctl (
        .aclk(aclk), .areset(areset), .i_req({s1_rd_req, s0_rd_req}), .i_ack(m_rd_ack),
        .o_take(w_rd_take), .o_issue(w_rd_issue), .o_win(w_rd_win),
        .o_m_req(m_rd_req), .o_s_ack(w_rd_sack), .o_timeout(rd_timeout)
    );

    // r_rd_cap holds last cycle's bank data, i.e. the ack-cycle data when sN_rd_ack fires
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_rd_data[n] = r_rd_hold[n];
            if (w_rd_sack[n]) w_rd_data[n] = rd_timeout ? '0 : r_rd_cap;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wa        <= '0;
            r_wbe       <= '0;
            r_wd        <= '0;
            r_ra        <= '0;
            r_rd_hold   <= '0;
            r_rd_cap    <= '0;
            r_m_wr_addr <= '0;
            r_m_wr_be   <= '0;
            r_m_wr_data <= '0;
            r_m_rd_addr <= '0;
        end else begin
            r_rd_cap <= m_rd_data;
            for (int n = 0; n < 2; n++) begin
                if (w_wr_take[n]) begin
                    r_wa[n]  <= w_wa[n];
                    r_wbe[n] <= w_wbe[n];
                    r_wd[n]  <= w_wd[n];
                end
                if (w_rd_take[n]) r_ra[n] <= w_ra[n];
                if (w_rd_sack[n]) r_rd_hold[n] <= w_rd_data[n];
            end
            if (w_wr_issue) begin
                r_m_wr_addr <= w_wr_take[w_wr_win] ? w_wa[w_wr_win]  : r_wa[w_wr_win];
                r_m_wr_be   <= w_wr_take[w_wr_win] ? w_wbe[w_wr_win] : r_wbe[w_wr_win];
                r_m_wr_data <= w_wr_take[w_wr_win] ? w_wd[w_wr_win]  : r_wd[w_wr_win];
            end
            if (w_rd_issue) begin
                r_m_rd_addr <= w_rd_take[w_rd_win] ? w_ra[w_rd_win] : r_ra[w_rd_win];
            end
        end
    end

    assign m_wr_addr  = r_m_wr_addr;
    assign m_wr_be    = r_m_wr_be;
    assign m_wr_data  = r_m_wr_data;
    assign m_rd_addr  = r_m_rd_addr;
    assign s0_wr_ack  = w_wr_sack[0];
    assign s1_wr_ack  = w_wr_sack[1];
    assign s0_rd_ack  = w_rd_sack[0];
    assign s1_rd_ack  = w_rd_sack[1];
    assign s0_rd_data = w_rd_data[0];
    assign s1_rd_data = w_rd_data[1];
endmodule

// File: tb/tb_ipif_arb2.sv
// tb/tb_ipif_arb2.sv - directed self-checking bench for ipif_arb2
// Inputs driven and outputs sampled 1 time unit after each rising edge.

module tb_ipif_arb2;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic [AW-1:0] s0_wr_addr, s1_wr_addr, s0_rd_addr, s1_rd_addr;
    logic          s0_wr_req, s1_wr_req, s0_rd_req, s1_rd_req;
    logic [BW-1:0] s0_wr_be, s1_wr_be;
    logic [DW-1:0] s0_wr_data, s1_wr_data;
    logic          s0_wr_ack, s1_wr_ack, s0_rd_ack, s1_rd_ack;
    logic [DW-1:0] s0_rd_data, s1_rd_data;
    logic [AW-1:0] m_wr_addr, m_rd_addr;
    logic [BW-1:0] m_wr_be;
    logic [DW-1:0] m_wr_data, m_rd_data;
    logic          m_wr_req, m_wr_ack, m_rd_req, m_rd_ack;
    logic          wr_timeout, rd_timeout;

    int checks = 0;
    int errors = 0;
    int ng;
    int n_ack;
    int n_req;

    ipif_arb2 #(.C_ADDR_WIDTH(12), .C_DATA_WIDTH(32), .C_TIMEOUT(4)) dut (
        .aclk(aclk), .areset(areset),
        .s0_wr_addr(s0_wr_addr), .s0_wr_req(s0_wr_req), .s0_wr_be(s0_wr_be),
        .s0_wr_data(s0_wr_data), .s0_wr_ack(s0_wr_ack),
        .s0_rd_addr(s0_rd_addr), .s0_rd_req(s0_rd_req), .s0_rd_data(s0_rd_data),
        .s0_rd_ack(s0_rd_ack),
        .s1_wr_addr(s1_wr_addr), .s1_wr_req(s1_wr_req), .s1_wr_be(s1_wr_be),
        .s1_wr_data(s1_wr_data), .s1_wr_ack(s1_wr_ack),
        .s1_rd_addr(s1_rd_addr), .s1_rd_req(s1_rd_req), .s1_rd_data(s1_rd_data),
        .s1_rd_ack(s1_rd_ack),
        .m_wr_addr(m_wr_addr), .m_wr_be(m_wr_be), .m_wr_data(m_wr_data),
        .m_wr_req(m_wr_req), .m_wr_ack(m_wr_ack),
        .m_rd_addr(m_rd_addr), .m_rd_req(m_rd_req), .m_rd_data(m_rd_data),
        .m_rd_ack(m_rd_ack),
        .wr_timeout(wr_timeout), .rd_timeout(rd_timeout)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
        s0_wr_req = 1'b0; s1_wr_req = 1'b0;
        s0_rd_req = 1'b0; s1_rd_req = 1'b0;
        m_wr_ack  = 1'b0; m_rd_ack  = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        s0_wr_addr = '0; s1_wr_addr = '0; s0_rd_addr = '0; s1_rd_addr = '0;
        s0_wr_req = 1'b0; s1_wr_req = 1'b0; s0_rd_req = 1'b0; s1_rd_req = 1'b0;
        s0_wr_be = '0; s1_wr_be = '0; s0_wr_data = '0; s1_wr_data = '0;
        m_wr_ack = 1'b0; m_rd_ack = 1'b0; m_rd_data = '0;
        do_reset();

        check("rst_m_wr_req", m_wr_req, 0);
        check("rst_m_rd_req", m_rd_req, 0);
        check("rst_m_wr_addr", m_wr_addr, 0);
        check("rst_acks", {s0_wr_ack, s1_wr_ack, s0_rd_ack, s1_rd_ack}, 0);
        check("rst_rd_data", {s0_rd_data, s1_rd_data}, 0);
        check("rst_timeouts", {wr_timeout, rd_timeout}, 0);

        // single write
        s0_wr_req = 1'b1; s0_wr_addr = 10'h012; s0_wr_data = 32'hDEADBEEF; s0_wr_be = 4'hF;
        step();
        check("w1_m_req", m_wr_req, 1);
        check("w1_m_addr", m_wr_addr, 10'h012);
        check("w1_m_data", m_wr_data, 32'hDEADBEEF);
        check("w1_m_be", m_wr_be, 4'hF);
        step();
        m_wr_ack = 1'b1;
        check("w1_m_req_c2", m_wr_req, 0);
        check("w1_ack_c2", s0_wr_ack, 0);
        step();
        check("w1_ack_c3", s0_wr_ack, 1);
        check("w1_s1_ack_c3", s1_wr_ack, 0);
        check("w1_timeout", wr_timeout, 0);
        step();
        check("w1_ack_c4", s0_wr_ack, 0);

        // contended read after reset
        do_reset();
        s0_rd_req = 1'b1; s0_rd_addr = 10'h004;
        s1_rd_req = 1'b1; s1_rd_addr = 10'h008;
        step();
        check("r2_m_req_c1", m_rd_req, 1);
        check("r2_m_addr_c1", m_rd_addr, 10'h004);
        step();
        m_rd_ack = 1'b1; m_rd_data = 32'h11111111;
        step();
        m_rd_data = 32'h0;
        check("r2_s0_ack_c3", s0_rd_ack, 1);
        check("r2_s0_data_c3", s0_rd_data, 32'h11111111);
        check("r2_s1_ack_c3", s1_rd_ack, 0);
        step();
        check("r2_m_req_c4", m_rd_req, 1);
        check("r2_m_addr_c4", m_rd_addr, 10'h008);
        step();
        m_rd_ack = 1'b1; m_rd_data = 32'h22222222;
        step();
        m_rd_data = 32'h0;
        check("r2_s1_ack_c6", s1_rd_ack, 1);
        check("r2_s1_data_c6", s1_rd_data, 32'h22222222);
        check("r2_s0_data_held", s0_rd_data, 32'h11111111);
        step();

        // timeout on both paths, no reset so s1_rd_data starts non-zero
        check("to_s1_data_pre", s1_rd_data, 32'h22222222);
        s1_wr_req = 1'b1; s1_wr_addr = 10'h03F;
        s1_rd_req = 1'b1; s1_rd_addr = 10'h03E;
        step();
        check("to_m_wr_req_c1", m_wr_req, 1);
        check("to_m_rd_req_c1", m_rd_req, 1);
        step();
        step();
        step();
        check("to_ack_c4", {s1_wr_ack, wr_timeout}, 0);
        step();
        check("to_wr_ack_c5", s1_wr_ack, 1);
        check("to_wr_timeout_c5", wr_timeout, 1);
        check("to_rd_ack_c5", s1_rd_ack, 1);
        check("to_rd_timeout_c5", rd_timeout, 1);
        check("to_rd_data_c5", s1_rd_data, 0);
        step();
        m_wr_ack = 1'b1; m_rd_ack = 1'b1; m_rd_data = 32'hFFFFFFFF;
        step();
        m_rd_data = 32'h0;
        check("stray_acks_c7", {s0_wr_ack, s1_wr_ack, s0_rd_ack, s1_rd_ack}, 0);
        check("stray_timeouts_c7", {wr_timeout, rd_timeout}, 0);
        check("stray_rd_data_c7", s1_rd_data, 0);
        check("stray_m_req_c7", {m_wr_req, m_rd_req}, 0);

        // round robin with continuous re-requests
        do_reset();
        s0_wr_addr = 10'h0A0; s1_wr_addr = 10'h0B1;
        s0_wr_req = 1'b1; s1_wr_req = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            step();
            if (s0_wr_ack) s0_wr_req = 1'b1;
            if (s1_wr_ack) s1_wr_req = 1'b1;
            if (m_wr_req) begin
                check($sformatf("rr_grant%0d", ng), m_wr_addr, (ng % 2 == 0) ? 10'h0A0 : 10'h0B1);
                m_wr_ack = 1'b1;
                ng++;
            end
        end
        check("rr_count", ng, 6);

        // concurrent write and read
        do_reset();
        s0_wr_req = 1'b1; s0_wr_addr = 10'h020; s0_wr_data = 32'hA5A5A5A5; s0_wr_be = 4'h3;
        s1_rd_req = 1'b1; s1_rd_addr = 10'h030;
        step();
        check("cc_m_reqs_c1", {m_wr_req, m_rd_req}, 2'b11);
        check("cc_m_wr_be", m_wr_be, 4'h3);
        check("cc_m_rd_addr", m_rd_addr, 10'h030);
        m_wr_ack = 1'b1;
        step();
        check("cc_wr_ack_c2", s0_wr_ack, 1);
        check("cc_rd_ack_c2", s1_rd_ack, 0);
        m_rd_ack = 1'b1; m_rd_data = 32'hCAFEF00D;
        step();
        m_rd_data = 32'h0;
        check("cc_rd_ack_c3", s1_rd_ack, 1);
        check("cc_rd_data_c3", s1_rd_data, 32'hCAFEF00D);
        check("cc_wr_ack_c3", s0_wr_ack, 0);

        // reset mid-transaction with s1 pending
        do_reset();
        s0_wr_req = 1'b1; s0_wr_addr = 10'h101;
        s1_wr_req = 1'b1; s1_wr_addr = 10'h202;
        step();
        check("rm_m_req_c1", m_wr_req, 1);
        step();
        areset = 1'b1;
        step();
        check("rm_m_wr_addr_c3", m_wr_addr, 0);
        check("rm_outs_c3", {m_wr_req, s0_wr_ack, s1_wr_ack, wr_timeout}, 0);
        areset = 1'b0;
        n_ack = 0;
        n_req = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (s0_wr_ack || s1_wr_ack || wr_timeout) n_ack++;
            if (m_wr_req) n_req++;
        end
        check("rm_no_ack", n_ack, 0);
        check("rm_no_req", n_req, 0);
        s1_rd_req = 1'b1; s1_rd_addr = 10'h055;
        step();
        check("rm_fresh_m_req", m_rd_req, 1);
        check("rm_fresh_addr", m_rd_addr, 10'h055);
        m_rd_ack = 1'b1; m_rd_data = 32'h5A5A0001;
        step();
        m_rd_data = 32'h0;
        check("rm_fresh_ack", s1_rd_ack, 1);
        check("rm_fresh_data", s1_rd_data, 32'h5A5A0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ipif_arb2.md
Name: ipif_arb2

Overview:
- Two-requester arbiter for the register-bank IPIF: wr_addr/wr_req/wr_be/wr_data/wr_ack and rd_addr/rd_req/rd_data/rd_ack.
- Lets two IPIF sources share one register bank, e.g. the AXI4-Lite IPIF bridge plus a debug/JTAG bridge.
- Write and read paths have independent round-robin arbiters. Each path has its own request capture, single-outstanding sequencing and timeout.

Parameters:
- C_ADDR_WIDTH, 12, byte address width; IPIF word address width is C_ADDR_WIDTH-2.
- C_DATA_WIDTH, 32, data width; only 32 or 64 is legal (simulation assert).
- C_TIMEOUT, 4, cycles to wait for downstream ack before a forced completion (1..15).

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- sN_wr_addr  in  C_ADDR_WIDTH-2  (N=0,1) requester N write word address, valid with sN_wr_req.
- sN_wr_req  in  1  requester N one-cycle write request pulse.
- sN_wr_be  in  C_DATA_WIDTH/8  requester N byte enables.
- sN_wr_data  in  C_DATA_WIDTH  requester N write data.
- sN_wr_ack  out  1  one-cycle write completion pulse to requester N.
- sN_rd_addr  in  C_ADDR_WIDTH-2  requester N read word address.
- sN_rd_req  in  1  requester N one-cycle read request pulse.
- sN_rd_data  out  C_DATA_WIDTH  read data; valid with sN_rd_ack, held until the next sN_rd_ack.
- sN_rd_ack  out  1  one-cycle read completion pulse.
- m_wr_addr, m_wr_be, m_wr_data  out  as above  to bank; held from issue until completion.
- m_wr_req  out  1  one-cycle write strobe to bank.
- m_wr_ack  in  1  bank write ack.
- m_rd_addr  out  C_ADDR_WIDTH-2  to bank; held from issue until completion.
- m_rd_req  out  1  one-cycle read strobe.
- m_rd_data  in  C_DATA_WIDTH  bank read data, sampled when m_rd_ack=1.
- m_rd_ack  in  1  bank read ack.
- wr_timeout, rd_timeout  out  1  one-cycle pulse on forced (timed-out) completion.

Behaviour:
- Reset: every output is 0; pending flags cleared; both FSMs IDLE; round-robin pointer = "last granted = 1", so requester 0 wins first.
- Capture: each path/requester has a pending flag and holding register (addr, be, data). A sN_x_req pulse sets the flag and loads the register.
  - A request arriving while that requester is already pending (or granted and incomplete) is ignored.
  - Compliant sources never issue one.
- Arbitration candidates: pending flag OR incoming request in the same cycle; an incoming request bypasses the holding register.
- Grant: one candidate wins. Two candidates: the one not last granted wins, then the pointer updates. The loser stays pending.
- FSM per path (IDLE, ISSUE, WAIT):
  - IDLE: any candidate -> ISSUE next cycle; the m_ address/be/data are loaded from the winner and m_x_req=1 for exactly the ISSUE cycle.
  - ISSUE/WAIT: ack is sampled in both states. m_x_ack=1 -> IDLE; sN_x_ack=1 next cycle to the granted requester. For reads, sN_rd_data = m_rd_data captured in the ack cycle.
  - ISSUE/WAIT with no ack -> WAIT. After C_TIMEOUT cycles counted from ISSUE with no ack -> IDLE, with sN_x_ack=1, x_timeout=1 and sN_rd_data=0 (reads) next cycle.
  - m_x_ack while IDLE (late or stray) is ignored.
- Latency (uncontended): request cycle T -> m_x_req at T+1. Ack at cycle K -> sN_x_ack at K+1, and FSM in IDLE at K+1. Next issue is at K+2 at the earliest.
- Only one transaction is outstanding per path; the write and read paths run concurrently and independently.
- Timeout sizing: worst-case request-to-ack under contention is 2*(C_TIMEOUT+2) cycles and must be below the 16-cycle source timeout; the default of 4 meets this.
- A request arriving on the completion cycle of the same requester's grant is captured normally.
- Reset mid-transaction: abandon the transaction, drop all pending requests, no ack is delivered; outputs go to 0 in the cycle after areset is sampled.

Test Plan:
- Single write: s0_wr_req at cycle 0, addr 0x012, data 0xDEADBEEF, be 0xF; bank acks at cycle 2 -> m_wr_req=1 only at cycle 1 with those values; s0_wr_ack at cycle 3; wr_timeout stays 0.
- Contended read after reset: s0_rd_req and s1_rd_req both at cycle 0 (addr 0x004 / 0x008); bank acks 1 cycle after each strobe with 0x11111111 / 0x22222222 ->
  - m_rd_req at cycle 1 (addr 0x004); s0_rd_ack at cycle 3 with 0x11111111.
  - m_rd_req at cycle 4 (addr 0x008); s1_rd_ack at cycle 6 with 0x22222222.
- Round robin: s0 and s1 request continuously (re-request on each ack) -> grants alternate 0,1,0,1 with no requester served twice in a row.
- Timeout: s1_wr_req at cycle 0, bank never acks, C_TIMEOUT=4 -> m_wr_req at cycle 1; s1_wr_ack and wr_timeout at cycle 5. A stray m_wr_ack at cycle 6 produces no output.
- Concurrency: s0 write and s1 read both at cycle 0 -> m_wr_req and m_rd_req both at cycle 1; acks complete independently.
- Reset mid-op: areset=1 at cycle 2 while in WAIT with s1 pending -> all outputs 0 from cycle 3; no sN_x_ack after reset release; a fresh s1_rd_req is served as the first grant.
